// File: rtl/x_muldiv_if.sv
// Execute-stage handshake bundle between the D/X latch and the RV32M unit.
// The master side drives the latched instruction/operands; the slave side is the unit.
interface x_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      i_insn;
  logic [WIDTH-1:0] i_regfile_A;
  logic [WIDTH-1:0] i_regfile_B;
  logic             i_flush;
  logic             o_stall;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_insn,
    output i_regfile_A,
    output i_regfile_B,
    output i_flush,
    input  o_stall,
    input  o_busy,
    input  o_valid,
    input  o_result
  );

  modport slave (
    input  i_insn,
    input  i_regfile_A,
    input  i_regfile_B,
    input  i_flush,
    output o_stall,
    output o_busy,
    output o_valid,
    output o_result
  );
endinterface

// File: rtl/x_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one step per cycle, stalling the front end while busy.
module x_muldiv #(
  parameter int WIDTH = 32
) (
  input logic        clock,
  input logic        reset,
  x_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc;
  logic               valid_q;
  logic [WIDTH-1:0]   res_q;

  logic [2:0]       f3;
  logic             is_m;
  logic             is_div;
  logic             sgn_a;
  logic             sgn_b;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] spec_res;

  assign f3     = bus.i_insn[14:12];
  assign is_m   = (bus.i_insn[6:0] == 7'b0110011) &&
                  (bus.i_insn[31:25] == 7'b0000001);
  assign is_div = f3[2];
  assign sgn_a  = (f3 == 3'b001) || (f3 == 3'b010) ||
                  (f3 == 3'b100) || (f3 == 3'b110);
  assign sgn_b  = (f3 == 3'b001) || (f3 == 3'b100) ||
                  (f3 == 3'b110);
  assign a_neg  = sgn_a & bus.i_regfile_A[WIDTH-1];
  assign b_neg  = sgn_b & bus.i_regfile_B[WIDTH-1];
  assign a_mag  = a_neg ? -bus.i_regfile_A : bus.i_regfile_A;
  assign b_mag  = b_neg ? -bus.i_regfile_B : bus.i_regfile_B;
  assign b_zero = (bus.i_regfile_B == '0);
  assign ovf    = ((f3 == 3'b100) || (f3 == 3'b110)) &&
                  (bus.i_regfile_A == MIN_NEG) &&
                  (bus.i_regfile_B == '1);
  assign special = is_div & (b_zero | ovf);

  // f3[1] separates the remainder ops from the quotient ops
  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      b_zero & ~f3[1]: spec_res = '1;
      b_zero &  f3[1]: spec_res = bus.i_regfile_A;
      ~b_zero & ~f3[1]: spec_res = MIN_NEG;
      default: spec_res = '0;
    endcase
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fin_res;
  logic               neg_ab;

  // acc holds {partial, multiplier} for mul, {remainder, dividend} for div
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
              (acc[0] ? {1'b0, mb} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = trial - {1'b0, mb};
    if (!diff[WIDTH])
      div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    acc_nxt = op[2] ? div_nxt : mul_nxt;
    neg_ab  = sa ^ sb;
    prod_f  = neg_ab ? -mul_nxt : mul_nxt;
    quo     = div_nxt[WIDTH-1:0];
    rem     = div_nxt[2*WIDTH-1:WIDTH];
    case (op)
      3'b000: fin_res = prod_f[WIDTH-1:0];
      3'b001,
      3'b010,
      3'b011: fin_res = prod_f[2*WIDTH-1:WIDTH];
      3'b100,
      3'b101: fin_res = neg_ab ? -quo : quo;
      default: fin_res = sa ? -rem : rem;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      mb      <= '0;
      acc     <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.i_flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (is_m) begin
              op  <= f3;
              sa  <= a_neg;
              sb  <= b_neg;
              mb  <= b_mag;
              acc <= {{WIDTH{1'b0}}, a_mag};
              cnt <= '0;
              if (special) begin
                state   <= DONE;
                valid_q <= 1'b1;
                res_q   <= spec_res;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) begin
              state   <= DONE;
              valid_q <= 1'b1;
              res_q   <= fin_res;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_stall = ~bus.i_flush &
                       (((state == IDLE) & is_m & ~special) |
                        (state == CALC));
  assign bus.o_busy   = (state == CALC);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = res_q;

  logic unused_ok;
  assign unused_ok = ^{bus.i_insn[24:15], bus.i_insn[11:7]};

endmodule

// File: tb/tb_x_muldiv.sv
// Bench for x_muldiv: table of M ops against a result scoreboard,
// plus flush, reset-abort and back-to-back sequences.
module tb_x_muldiv;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  x_muldiv_if bus ();

  x_muldiv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  localparam logic [31:0] NOP = 32'h00000013;

  vec_t        vecs[$];
  logic [31:0] expq[$];
  time         vtimes[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && bus.o_valid) begin
      vtimes.push_back($time);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_valid: got result %h with nothing pending",
                 bus.o_result);
      end else begin
        chk("scoreboard_result", bus.o_result, expq.pop_front());
      end
    end
  end

  task automatic run_op(input vec_t v);
    int  stalls;
    bit  done;
    expq.push_back(v.exp);
    bus.i_insn      = mk(v.f3);
    bus.i_regfile_A = v.a;
    bus.i_regfile_B = v.b;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus.o_stall) stalls++;
      @(negedge clock);
      done = bus.o_valid;
    end
    chk({v.name, "_valid"}, 32'(done), 32'd1);
    chk({v.name, "_stalls"}, stalls, v.spec ? 32'd0 : 32'd33);
    if (!done) expq.delete();
    // keep the insn in D/X across the DONE edge: it must not restart
    @(posedge clock);
    #1;
    bus.i_insn = NOP;
    repeat (3) @(negedge clock);
    chk({v.name, "_retain"}, bus.o_result, v.exp);
    chk({v.name, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int n0;
    vecs.push_back('{"mul_7_m3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{"mulh",        3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{"mulhsu",      3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0});
    vecs.push_back('{"mulhu",       3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0});
    vecs.push_back('{"mulhu_ones",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"mul_ones",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0});
    vecs.push_back('{"div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       1'b0});
    vecs.push_back('{"remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        1'b0});
    vecs.push_back('{"div_m100_m7", 3'b100, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0});
    vecs.push_back('{"rem_m100_m7", 3'b110, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"div_100_m7",  3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0});
    vecs.push_back('{"rem_100_m7",  3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        1'b0});
    vecs.push_back('{"div_by0",     3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"rem_by0",     3'b110, 32'd5,        32'd0,        32'd5,        1'b1});
    vecs.push_back('{"divu_by0",    3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"remu_by0",    3'b111, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b1});
    vecs.push_back('{"div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{"rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1});

    bus.i_insn      = NOP;
    bus.i_regfile_A = '0;
    bus.i_regfile_B = '0;
    bus.i_flush     = 1'b0;
    #12;
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_result", bus.o_result, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // flush mid-CALC: no result may appear
    bus.i_insn      = mk(3'b000);
    bus.i_regfile_A = 32'd7;
    bus.i_regfile_B = 32'd3;
    @(posedge clock);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("flush_calc_busy", 32'(bus.o_busy), 32'd1);
    bus.i_flush = 1'b1;
    #1;
    chk("flush_calc_stall", 32'(bus.o_stall), 32'd0);
    @(posedge clock);
    #1;
    chk("flush_calc_idle", 32'(bus.o_busy), 32'd0);
    bus.i_flush = 1'b0;
    bus.i_insn  = NOP;
    repeat (40) @(negedge clock);

    // flush beats acceptance in IDLE, normal and special ops
    bus.i_insn      = mk(3'b101);
    bus.i_regfile_A = 32'd100;
    bus.i_regfile_B = 32'd7;
    bus.i_flush     = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(bus.o_stall), 32'd0);
    @(posedge clock);
    #1;
    chk("flush_idle_busy", 32'(bus.o_busy), 32'd0);
    bus.i_insn      = mk(3'b100);
    bus.i_regfile_B = 32'd0;
    @(posedge clock);
    #1;
    bus.i_flush = 1'b0;
    bus.i_insn  = NOP;
    @(negedge clock);
    chk("flush_special_valid", 32'(bus.o_valid), 32'd0);
    repeat (5) @(negedge clock);

    // back-to-back: DIVU then MUL, valid pulses 34 cycles apart
    n0 = vtimes.size();
    expq.push_back(32'd14);
    expq.push_back(32'hFFFFFFEB);
    bus.i_insn      = mk(3'b101);
    bus.i_regfile_A = 32'd100;
    bus.i_regfile_B = 32'd7;
    for (int c = 0; c < 40 && vtimes.size() < n0 + 1; c++) begin
      @(negedge clock);
      #1;
    end
    bus.i_insn      = mk(3'b000);
    bus.i_regfile_A = 32'd7;
    bus.i_regfile_B = 32'hFFFFFFFD;
    for (int c = 0; c < 80 && vtimes.size() < n0 + 2; c++) begin
      @(negedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    bus.i_insn = NOP;
    chk("b2b_count", vtimes.size() - n0, 32'd2);
    if (vtimes.size() >= n0 + 2)
      chk("b2b_gap", 32'(vtimes[n0+1] - vtimes[n0]), 32'd340);
    expq.delete();
    repeat (40) @(negedge clock);

    // async reset mid-CALC aborts at once
    bus.i_insn      = mk(3'b000);
    bus.i_regfile_A = 32'd3;
    bus.i_regfile_B = 32'd5;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
    reset      = 1'b0;
    bus.i_insn = NOP;
    #1;
    chk("mid_rst_stall", 32'(bus.o_stall), 32'd0);
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_result", bus.o_result, 32'd0);
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("post_rst_stall", 32'(bus.o_stall), 32'd0);
    chk("pending_empty", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_muldiv.md
Name: x_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the D/X pipeline latch.
- Consumes the latched instruction and both register-file operands.
- Holds the pipeline via o_stall while a multi-cycle operation runs.
- Presents a one-cycle-valid 32-bit result to the X/M path.
- Non-M instructions pass through untouched: no stall, no valid.

Parameters:
WIDTH, 32, operand/result width; counter width is $clog2(WIDTH); only 32 is supported for RV32M.

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (low = reset asserted)
i_insn  input  32  instruction from D/X latch
i_regfile_A  input  32  rs1 value from D/X latch
i_regfile_B  input  32  rs2 value from D/X latch
i_flush  input  1  kill any in-flight operation (branch mispredict / trap)
o_stall  output  1  hold F/D and D/X latches and PC
o_busy  output  1  high in CALC
o_valid  output  1  result valid, exactly one cycle per completed op
o_result  output  32  M-extension result

Behaviour:
- M instruction detect (is_m): opcode==7'b0110011 and funct7==7'b0000001.
- funct3 selects: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Reset (reset low, async):
  - state=IDLE, counter=0.
  - o_valid=0, o_busy=0, o_result=0.
  - All operand/accumulator registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - If is_m and !i_flush: latch operands as magnitudes plus sign flags, and the op.
    - Signed for MULH/DIV/REM both operands; MULHSU rs1 only.
  - Special cases go IDLE->DONE in one edge, result computed directly:
    - DIV/DIVU with rs2==0: quotient 32'hFFFFFFFF.
    - REM/REMU with rs2==0: remainder = rs1.
    - DIV with rs1==32'h80000000, rs2==32'hFFFFFFFF: quotient 32'h80000000.
    - REM with rs1==32'h80000000, rs2==32'hFFFFFFFF: remainder 0.
  - Otherwise IDLE->CALC, counter=0.
- CALC:
  - One radix-2 step per cycle, counter increments.
  - Multiply: shift-add into 64-bit accumulator.
  - Divide: restoring divide, 32-bit remainder/quotient shift.
  - When counter==WIDTH-1: apply sign fix-up and select the result, then go to DONE.
    - Product negated if signs differ.
    - Quotient negated if signs differ.
    - Remainder takes the dividend sign.
    - MUL low 32 bits; MULH* high 32 bits.
- DONE:
  - o_valid=1 and o_result holds for this one cycle; o_stall=0.
  - Unconditionally returns to IDLE; the instruction still in D/X this cycle must NOT restart.
- o_stall (combinational) = !i_flush & ((state==IDLE & is_m & !special) | state==CALC).
- o_busy = (state==CALC).
- Latency (normal op):
  - Accept edge E0.
  - 32 CALC edges; DONE entered on E32.
  - o_valid high between E32 and E33.
- Latency (special case): o_valid high between E0 and E1.
- Flush:
  - i_flush high in any state -> IDLE at next edge, o_valid=0, no result emitted.
  - Flush has priority over acceptance in IDLE.
- o_result retains its last value outside DONE; it is updated only on entry to DONE.
- Async reset mid-CALC aborts immediately; no o_valid afterwards.
- Back-to-back M instructions:
  - Second insn is evaluated in the IDLE cycle after DONE.
  - Gap of exactly one non-stalled cycle (the DONE cycle) between them.

Test Plan:
- Reset low mid-CALC -> state IDLE, o_stall=0, o_valid=0, o_result=0 immediately; release -> stays idle with non-M insn.
- MUL rs1=7, rs2=-3 (32'hFFFFFFFD) -> o_stall high 33 cycles, then o_valid one cycle with o_result=32'hFFFFFFEB.
- MULH/MULHSU/MULHU with rs1=32'h80000000, rs2=32'hFFFFFFFF -> 32'h00000000 / 32'h80000000 / 32'h7FFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero (DIV 5/0 -> 32'hFFFFFFFF, REM 5/0 -> 5) and overflow (DIV 32'h80000000/-1 -> 32'h80000000) -> o_valid one cycle after accept, no CALC, o_stall never high.
- i_flush pulsed at CALC cycle 10 -> IDLE next edge, o_valid never asserts; back-to-back DIVU then MUL -> two valid pulses 34 cycles apart, no restart of the first op.
